// File: rtl/ir_assembler.sv
// Instruction register: assembles BEATS bus beats of BUS_W bits, MSB-first, into one word.
// Optional parity checking on each beat is enabled with `define IR_PARITY_EN.
module ir_assembler #(
    parameter int unsigned BUS_W = 8,
    parameter int unsigned BEATS = 2,
    parameter int unsigned OPC_W = 3,
    localparam int unsigned W     = BUS_W * BEATS,
    localparam int unsigned IDX_W = ($clog2(BEATS) < 1) ? 1 : $clog2(BEATS)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ena,
    input  logic               flush,
    input  logic [BUS_W-1:0]   data,
    output logic [W-1:0]       opc_iraddr,
    output logic [OPC_W-1:0]   opcode,
    output logic [W-OPC_W-1:0] iraddr,
    output logic [IDX_W-1:0]   beat_idx,
    output logic               ir_valid,
    output logic               ir_done
`ifdef IR_PARITY_EN
    ,
    input  logic               data_par,
    output logic               par_err
`endif
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BEATS - 1);

    logic [W-1:0]     word_q, word_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             valid_q, valid_d;
    logic             done_q, done_d;
    logic             idx_legal;

    assign idx_legal = (32'(idx_q) < BEATS);

    always_comb begin
        word_d  = word_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        done_d  = 1'b0;
        if (flush) begin
            idx_d   = '0;
            valid_d = 1'b0;
        end else if (ena) begin
            if (!idx_legal) begin
                idx_d = '0;
            end else begin
                // Beat 0 starts a fresh word so no stale low slices survive
                if (idx_q == '0) begin
                    word_d  = '0;
                    valid_d = 1'b0;
                end
                for (int unsigned k = 0; k < BEATS; k++) begin
                    if (idx_q == IDX_W'(k)) begin
                        word_d[W-1-k*BUS_W -: BUS_W] = data;
                    end
                end
                if (idx_q == LAST_IDX) begin
                    idx_d   = '0;
                    valid_d = 1'b1;
                    done_d  = 1'b1;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
        end else begin
            idx_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            word_q  <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            word_q  <= word_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    assign opc_iraddr = word_q;
    assign opcode     = word_q[W-1 -: OPC_W];
    assign iraddr     = word_q[W-OPC_W-1:0];
    assign beat_idx   = idx_q;
    assign ir_valid   = valid_q;
    assign ir_done    = done_q;

`ifdef IR_PARITY_EN
    logic flag_q, flag_d;
    logic perr_q, perr_d;
    logic beat_bad;

    // Even parity: data_par must equal the XOR of all data bits
    assign beat_bad = data_par ^ (^data);

    always_comb begin
        flag_d = flag_q;
        perr_d = perr_q;
        if (flush) begin
            flag_d = 1'b0;
            perr_d = 1'b0;
        end else if (ena) begin
            if (!idx_legal) begin
                flag_d = 1'b0;
            end else if (idx_q == LAST_IDX) begin
                perr_d = flag_q | beat_bad;
                flag_d = 1'b0;
            end else if (idx_q == '0) begin
                flag_d = beat_bad;
            end else begin
                flag_d = flag_q | beat_bad;
            end
        end else begin
            flag_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            flag_q <= 1'b0;
            perr_q <= 1'b0;
        end else begin
            flag_q <= flag_d;
            perr_q <= perr_d;
        end
    end

    assign par_err = perr_q;
`endif

endmodule

// File: tb/tb_ir_assembler.sv
// Directed bench for ir_assembler: default 2x8 instance plus a 3x8 instance with a 4-bit opcode.
// Parity checks are compiled in when IR_PARITY_EN is defined.
module tb_ir_assembler;

    logic        clk;
    logic        rst;

    logic        ena, flush;
    logic [7:0]  data;
    logic [15:0] opc;
    logic [2:0]  opcode;
    logic [12:0] iraddr;
    logic [0:0]  idx;
    logic        valid, done;

    logic        ena3, flush3;
    logic [7:0]  data3;
    logic [23:0] opc3;
    logic [3:0]  opcode3;
    logic [19:0] iraddr3;
    logic [1:0]  idx3;
    logic        valid3, done3;

    int n_checks;
    int n_fail;

`ifdef IR_PARITY_EN
    logic data_par, par_err;
    logic data_par3, par_err3;
    assign data_par3 = ^data3;
`endif

    ir_assembler dut (
        .clk        (clk),
        .rst        (rst),
        .ena        (ena),
        .flush      (flush),
        .data       (data),
        .opc_iraddr (opc),
        .opcode     (opcode),
        .iraddr     (iraddr),
        .beat_idx   (idx),
        .ir_valid   (valid),
        .ir_done    (done)
`ifdef IR_PARITY_EN
        ,
        .data_par   (data_par),
        .par_err    (par_err)
`endif
    );

    ir_assembler #(.BUS_W(8), .BEATS(3), .OPC_W(4)) dut3 (
        .clk        (clk),
        .rst        (rst),
        .ena        (ena3),
        .flush      (flush3),
        .data       (data3),
        .opc_iraddr (opc3),
        .opcode     (opcode3),
        .iraddr     (iraddr3),
        .beat_idx   (idx3),
        .ir_valid   (valid3),
        .ir_done    (done3)
`ifdef IR_PARITY_EN
        ,
        .data_par   (data_par3),
        .par_err    (par_err3)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; ena = 1'b0; flush = 1'b0; data = '0;
        ena3 = 1'b0; flush3 = 1'b0; data3 = '0;
`ifdef IR_PARITY_EN
        data_par = 1'b0;
`endif
        #2 rst = 1'b0;
        step();
        step();
        n_checks++; if (opc !== 16'h0) begin n_fail++; $display("FAIL reset_opc: got %h expected %h", opc, 16'h0); end
        n_checks++; if (idx !== 1'b0) begin n_fail++; $display("FAIL reset_idx: got %h expected %h", idx, 1'b0); end
        n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", valid); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
        n_checks++; if (opc3 !== 24'h0) begin n_fail++; $display("FAIL reset_opc3: got %h expected %h", opc3, 24'h0); end
        n_checks++; if (idx3 !== 2'd0) begin n_fail++; $display("FAIL reset_idx3: got %h expected 0", idx3); end
        #2 rst = 1'b1;
    endtask

    task automatic test_basic();
        ena = 1'b1; data = 8'hA5;
        step();
        n_checks++; if (idx !== 1'b1) begin n_fail++; $display("FAIL basic_idx1: got %h expected 1", idx); end
        n_checks++; if (opc !== 16'hA500) begin n_fail++; $display("FAIL basic_opc1: got %h expected %h", opc, 16'hA500); end
        n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL basic_valid1: got %b expected 0", valid); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL basic_done1: got %b expected 0", done); end
        data = 8'h3C;
        step();
        n_checks++; if (opc !== 16'hA53C) begin n_fail++; $display("FAIL basic_opc2: got %h expected %h", opc, 16'hA53C); end
        n_checks++; if (opcode !== 3'b101) begin n_fail++; $display("FAIL basic_opcode: got %b expected 101", opcode); end
        n_checks++; if (iraddr !== 13'h053C) begin n_fail++; $display("FAIL basic_iraddr: got %h expected %h", iraddr, 13'h053C); end
        n_checks++; if (valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid2: got %b expected 1", valid); end
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL basic_done2: got %b expected 1", done); end
        n_checks++; if (idx !== 1'b0) begin n_fail++; $display("FAIL basic_idx2: got %h expected 0", idx); end
        ena = 1'b0;
        step();
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL basic_done_pulse: got %b expected 0", done); end
        n_checks++; if (valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid_hold: got %b expected 1", valid); end
        n_checks++; if (opc !== 16'hA53C) begin n_fail++; $display("FAIL basic_opc_hold: got %h expected %h", opc, 16'hA53C); end
    endtask

    task automatic test_three_beat();
        ena3 = 1'b1; data3 = 8'h12;
        step();
        n_checks++; if (opc3 !== 24'h120000) begin n_fail++; $display("FAIL three_opc1: got %h expected %h", opc3, 24'h120000); end
        n_checks++; if (idx3 !== 2'd1) begin n_fail++; $display("FAIL three_idx1: got %h expected 1", idx3); end
        data3 = 8'h34;
        step();
        n_checks++; if (opc3 !== 24'h123400) begin n_fail++; $display("FAIL three_opc2: got %h expected %h", opc3, 24'h123400); end
        n_checks++; if (idx3 !== 2'd2) begin n_fail++; $display("FAIL three_idx2: got %h expected 2", idx3); end
        n_checks++; if (done3 !== 1'b0 || valid3 !== 1'b0) begin n_fail++; $display("FAIL three_status2: got done=%b valid=%b expected 0 0", done3, valid3); end
        data3 = 8'h56;
        step();
        n_checks++; if (opc3 !== 24'h123456) begin n_fail++; $display("FAIL three_opc3: got %h expected %h", opc3, 24'h123456); end
        n_checks++; if (opcode3 !== 4'h1) begin n_fail++; $display("FAIL three_opcode: got %h expected 1", opcode3); end
        n_checks++; if (iraddr3 !== 20'h23456) begin n_fail++; $display("FAIL three_iraddr: got %h expected %h", iraddr3, 20'h23456); end
        n_checks++; if (valid3 !== 1'b1 || done3 !== 1'b1) begin n_fail++; $display("FAIL three_status3: got valid=%b done=%b expected 1 1", valid3, done3); end
        n_checks++; if (idx3 !== 2'd0) begin n_fail++; $display("FAIL three_idx3: got %h expected 0", idx3); end
        data3 = 8'hFF;
        step();
        n_checks++; if (opc3 !== 24'hFF0000) begin n_fail++; $display("FAIL three_opc_next: got %h expected %h", opc3, 24'hFF0000); end
        n_checks++; if (valid3 !== 1'b0 || done3 !== 1'b0) begin n_fail++; $display("FAIL three_status_next: got valid=%b done=%b expected 0 0", valid3, done3); end
        ena3 = 1'b0;
        step();
        n_checks++; if (idx3 !== 2'd0) begin n_fail++; $display("FAIL three_abandon_idx: got %h expected 0", idx3); end
        n_checks++; if (opc3 !== 24'hFF0000) begin n_fail++; $display("FAIL three_abandon_opc: got %h expected %h", opc3, 24'hFF0000); end
    endtask

    task automatic test_gap();
        ena = 1'b1; data = 8'hAA;
        step();
        ena = 1'b0;
        step();
        n_checks++; if (idx !== 1'b0) begin n_fail++; $display("FAIL gap_idx: got %h expected 0", idx); end
        n_checks++; if (done !== 1'b0 || valid !== 1'b0) begin n_fail++; $display("FAIL gap_status: got done=%b valid=%b expected 0 0", done, valid); end
        n_checks++; if (opc !== 16'hAA00) begin n_fail++; $display("FAIL gap_opc: got %h expected %h", opc, 16'hAA00); end
        ena = 1'b1; data = 8'h11;
        step();
        n_checks++; if (opc !== 16'h1100) begin n_fail++; $display("FAIL gap_restart: got %h expected %h", opc, 16'h1100); end
        data = 8'h22;
        step();
        n_checks++; if (opc !== 16'h1122) begin n_fail++; $display("FAIL gap_final: got %h expected %h", opc, 16'h1122); end
        n_checks++; if (done !== 1'b1 || valid !== 1'b1) begin n_fail++; $display("FAIL gap_final_status: got done=%b valid=%b expected 1 1", done, valid); end
        ena = 1'b0;
        step();
    endtask

    task automatic test_flush();
        ena = 1'b1; data = 8'h77;
        step();
        flush = 1'b1; data = 8'h88;
        step();
        n_checks++; if (idx !== 1'b0) begin n_fail++; $display("FAIL flush_idx: got %h expected 0", idx); end
        n_checks++; if (valid !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL flush_status: got valid=%b done=%b expected 0 0", valid, done); end
        n_checks++; if (opc !== 16'h7700) begin n_fail++; $display("FAIL flush_opc: got %h expected %h", opc, 16'h7700); end
        flush = 1'b0; data = 8'h12;
        step();
        data = 8'h34;
        step();
        n_checks++; if (valid !== 1'b1 || opc !== 16'h1234) begin n_fail++; $display("FAIL flush_reload: got valid=%b opc=%h expected 1 1234", valid, opc); end
        ena = 1'b0; flush = 1'b1;
        step();
        n_checks++; if (valid !== 1'b0 || opc !== 16'h1234) begin n_fail++; $display("FAIL flush_complete: got valid=%b opc=%h expected 0 1234", valid, opc); end
        flush = 1'b0;
        step();
    endtask

    task automatic test_async_reset();
        ena = 1'b1; data = 8'hC3;
        step();
        n_checks++; if (idx !== 1'b1) begin n_fail++; $display("FAIL areset_pre_idx: got %h expected 1", idx); end
        #2 rst = 1'b0;
        #1;
        n_checks++; if (opc !== 16'h0 || idx !== 1'b0) begin n_fail++; $display("FAIL areset_opc_idx: got opc=%h idx=%h expected 0 0", opc, idx); end
        n_checks++; if (valid !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL areset_status: got valid=%b done=%b expected 0 0", valid, done); end
        n_checks++; if (opc3 !== 24'h0) begin n_fail++; $display("FAIL areset_opc3: got %h expected 0", opc3); end
        #1 rst = 1'b1;
        data = 8'h5A;
        step();
        data = 8'h0F;
        step();
        n_checks++; if (opc !== 16'h5A0F || valid !== 1'b1 || done !== 1'b1) begin n_fail++; $display("FAIL areset_reload: got opc=%h valid=%b done=%b expected 5a0f 1 1", opc, valid, done); end
        ena = 1'b0;
        step();
    endtask

    task automatic test_back_to_back();
        int pulses;
        pulses = 0;
        ena = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            data = 8'(i);
            step();
            if (done === 1'b1) pulses++;
            if (i % 2 == 1) begin
                n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL b2b_valid_low beat %0d: got %b expected 0", i, valid); end
            end else begin
                n_checks++; if (opc !== {8'(i - 1), 8'(i)} || valid !== 1'b1) begin n_fail++; $display("FAIL b2b_word beat %0d: got opc=%h valid=%b expected %h 1", i, opc, valid, {8'(i - 1), 8'(i)}); end
            end
        end
        ena = 1'b0;
        step();
        if (done === 1'b1) pulses++;
        n_checks++; if (pulses !== 3) begin n_fail++; $display("FAIL b2b_pulses: got %0d expected 3", pulses); end
    endtask

`ifdef IR_PARITY_EN
    task automatic test_parity();
        ena = 1'b1; data = 8'hA5; data_par = 1'b1;
        step();
        data = 8'h3C; data_par = 1'b0;
        step();
        n_checks++; if (par_err !== 1'b1 || valid !== 1'b1) begin n_fail++; $display("FAIL parity_err: got par_err=%b valid=%b expected 1 1", par_err, valid); end
        data = 8'h5A; data_par = 1'b0;
        step();
        n_checks++; if (par_err !== 1'b1) begin n_fail++; $display("FAIL parity_hold: got %b expected 1", par_err); end
        data = 8'h0F; data_par = 1'b0;
        step();
        n_checks++; if (par_err !== 1'b0) begin n_fail++; $display("FAIL parity_clean: got %b expected 0", par_err); end
        data = 8'h01; data_par = 1'b0;
        step();
        data = 8'h00; data_par = 1'b0;
        step();
        n_checks++; if (par_err !== 1'b1) begin n_fail++; $display("FAIL parity_err2: got %b expected 1", par_err); end
        ena = 1'b0; flush = 1'b1;
        step();
        n_checks++; if (par_err !== 1'b0) begin n_fail++; $display("FAIL parity_flush: got %b expected 0", par_err); end
        n_checks++; if (par_err3 !== 1'b0) begin n_fail++; $display("FAIL parity_dut3: got %b expected 0", par_err3); end
        flush = 1'b0;
        step();
    endtask
`endif

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_basic();
        test_three_beat();
        test_gap();
        test_flush();
        test_async_reset();
        test_back_to_back();
`ifdef IR_PARITY_EN
        test_parity();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
